// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/DMA arbiter sequencing accesses to the single-port data memory
// Optional DMA anti-starvation counter: define DMEM_ARB_FAIRNESS_EN.
module dmem_arbiter #(
    parameter int ACC_CYCLES   = 1,
    parameter int STARVE_LIMIT = 8,
    parameter int AW           = 32,
    parameter int DW           = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          cpu_req_i,
    input  logic          cpu_we_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [DW-1:0] cpu_wdata_i,
    output logic [DW-1:0] cpu_rdata_o,
    output logic          cpu_done_o,
    output logic          cpu_stall_o,
    input  logic          dma_req_i,
    input  logic          dma_we_i,
    input  logic [AW-1:0] dma_addr_i,
    input  logic [DW-1:0] dma_wdata_i,
    output logic [DW-1:0] dma_rdata_o,
    output logic          dma_ack_o,
    output logic          dmem_we_o,
    output logic [AW-1:0] dmem_addr_o,
    output logic [DW-1:0] dmem_wdata_o,
    input  logic [DW-1:0] dmem_rdata_i
);
    localparam int            CW       = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ACC_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACC_CPU = 2'd1,
        ACC_DMA = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          acc_last;
    logic          arb_pt;
    logic          dma_prio;

    if (ACC_CYCLES < 1 || STARVE_LIMIT < 1) begin : g_param_check
        $error("dmem_arbiter: ACC_CYCLES and STARVE_LIMIT must be >= 1");
    end

    // Re-arbitrating in the final access cycle gives back-to-back accesses without a bubble.
    assign acc_last = (state_q != IDLE) && (cnt_q == CNT_LAST);
    assign arb_pt   = (state_q == IDLE) || acc_last;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        if (arb_pt) begin
            cnt_d = '0;
            if (dma_req_i && dma_prio) begin
                state_d = ACC_DMA;
            end else if (cpu_req_i) begin
                state_d = ACC_CPU;
            end else if (dma_req_i) begin
                state_d = ACC_DMA;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef DMEM_ARB_FAIRNESS_EN
    localparam int            SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [SW-1:0] starve_q, starve_d;

    // Counts every cycle the DMA waits, idle cycles included; a grant clears it.
    always_comb begin
        starve_d = starve_q;
        if (arb_pt && state_d == ACC_DMA) begin
            starve_d = '0;
        end else if (dma_req_i && state_q != ACC_DMA && starve_q != STARVE_MAX) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    assign dma_prio = (starve_q == STARVE_MAX);
`else
    assign dma_prio = 1'b0;
`endif

    // Pulses and the write strobe exist only in the final access cycle, so each write lands once.
    always_comb begin
        cpu_done_o   = (state_q == ACC_CPU) && acc_last;
        dma_ack_o    = (state_q == ACC_DMA) && acc_last;
        cpu_stall_o  = cpu_req_i && !cpu_done_o;
        dmem_we_o    = (cpu_done_o && cpu_we_i) || (dma_ack_o && dma_we_i);
        dmem_addr_o  = '0;
        dmem_wdata_o = '0;
        if (state_q == ACC_CPU) begin
            dmem_addr_o  = cpu_addr_i;
            dmem_wdata_o = cpu_wdata_i;
        end else if (state_q == ACC_DMA) begin
            dmem_addr_o  = dma_addr_i;
            dmem_wdata_o = dma_wdata_i;
        end
        cpu_rdata_o = cpu_done_o ? dmem_rdata_i : '0;
        dma_rdata_o = dma_ack_o  ? dmem_rdata_i : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed bench for dmem_arbiter (instance a: ACC_CYCLES=1, instance b: ACC_CYCLES=3)
module tb_dmem_arbiter;
`ifdef DMEM_ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic        clk, rst_n;

    logic        a_cpu_req, a_cpu_we, a_dma_req, a_dma_we;
    logic [31:0] a_cpu_addr, a_cpu_wdata, a_dma_addr, a_dma_wdata;
    logic [31:0] a_cpu_rdata, a_dma_rdata, a_dmem_addr, a_dmem_wdata, a_dmem_rdata;
    logic        a_cpu_done, a_cpu_stall, a_dma_ack, a_dmem_we;

    logic        b_cpu_req, b_cpu_we, b_dma_req, b_dma_we;
    logic [31:0] b_cpu_addr, b_cpu_wdata, b_dma_addr, b_dma_wdata;
    logic [31:0] b_cpu_rdata, b_dma_rdata, b_dmem_addr, b_dmem_wdata, b_dmem_rdata;
    logic        b_cpu_done, b_cpu_stall, b_dma_ack, b_dmem_we;

    logic [31:0] a_mem [0:63];
    logic [31:0] b_mem [0:63];
    int          n_pass = 0;
    int          n_chk  = 0;
    int          b_bad_wr = 0;

    dmem_arbiter #(.ACC_CYCLES(1), .STARVE_LIMIT(4), .AW(32), .DW(32)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .cpu_req_i(a_cpu_req), .cpu_we_i(a_cpu_we), .cpu_addr_i(a_cpu_addr), .cpu_wdata_i(a_cpu_wdata),
        .cpu_rdata_o(a_cpu_rdata), .cpu_done_o(a_cpu_done), .cpu_stall_o(a_cpu_stall),
        .dma_req_i(a_dma_req), .dma_we_i(a_dma_we), .dma_addr_i(a_dma_addr), .dma_wdata_i(a_dma_wdata),
        .dma_rdata_o(a_dma_rdata), .dma_ack_o(a_dma_ack),
        .dmem_we_o(a_dmem_we), .dmem_addr_o(a_dmem_addr), .dmem_wdata_o(a_dmem_wdata),
        .dmem_rdata_i(a_dmem_rdata)
    );

    dmem_arbiter #(.ACC_CYCLES(3), .STARVE_LIMIT(4), .AW(32), .DW(32)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .cpu_req_i(b_cpu_req), .cpu_we_i(b_cpu_we), .cpu_addr_i(b_cpu_addr), .cpu_wdata_i(b_cpu_wdata),
        .cpu_rdata_o(b_cpu_rdata), .cpu_done_o(b_cpu_done), .cpu_stall_o(b_cpu_stall),
        .dma_req_i(b_dma_req), .dma_we_i(b_dma_we), .dma_addr_i(b_dma_addr), .dma_wdata_i(b_dma_wdata),
        .dma_rdata_o(b_dma_rdata), .dma_ack_o(b_dma_ack),
        .dmem_we_o(b_dmem_we), .dmem_addr_o(b_dmem_addr), .dmem_wdata_o(b_dmem_wdata),
        .dmem_rdata_i(b_dmem_rdata)
    );

    assign a_dmem_rdata = a_mem[a_dmem_addr[7:2]];
    assign b_dmem_rdata = b_mem[b_dmem_addr[7:2]];

    always @(posedge clk) begin
        if (a_dmem_we) a_mem[a_dmem_addr[7:2]] <= a_dmem_wdata;
        if (b_dmem_we) b_mem[b_dmem_addr[7:2]] <= b_dmem_wdata;
        if (b_dmem_we && b_dmem_addr == 32'h50) b_bad_wr <= b_bad_wr + 1;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish within 50000 time units");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        a_cpu_req = 1'b1; a_cpu_we = 1'b0; a_cpu_addr = '0; a_cpu_wdata = '0;
        a_dma_req = 1'b0; a_dma_we = 1'b0; a_dma_addr = '0; a_dma_wdata = '0;
        b_cpu_req = 1'b0; b_cpu_we = 1'b0; b_cpu_addr = '0; b_cpu_wdata = '0;
        b_dma_req = 1'b0; b_dma_we = 1'b0; b_dma_addr = '0; b_dma_wdata = '0;
        #2;
        check("rst stall follows req", a_cpu_stall, 1);
        check("rst cpu_done", a_cpu_done, 0);
        check("rst dma_ack", a_dma_ack, 0);
        check("rst dmem_we", a_dmem_we, 0);
        check("rst dmem_addr", a_dmem_addr, 0);
        check("rst cpu_rdata", a_cpu_rdata, 0);
        check("rst b dmem_addr", b_dmem_addr, 0);
        a_cpu_req = 1'b0;
        step(); step();
        rst_n = 1'b1;

        // ACC_CYCLES=1 store then load of 0x10
        step();
        a_cpu_req = 1'b1; a_cpu_we = 1'b1; a_cpu_addr = 32'h10; a_cpu_wdata = 32'hDEADBEEF;
        #1;
        check("t1 st stall", a_cpu_stall, 1);
        check("t1 st idle addr", a_dmem_addr, 0);
        check("t1 st we early", a_dmem_we, 0);
        step();
        check("t1 st done", a_cpu_done, 1);
        check("t1 st stall off", a_cpu_stall, 0);
        check("t1 st we", a_dmem_we, 1);
        check("t1 st addr", a_dmem_addr, 32'h10);
        check("t1 st wdata", a_dmem_wdata, 32'hDEADBEEF);
        a_cpu_req = 1'b0;
        step();
        a_cpu_req = 1'b1; a_cpu_we = 1'b0;
        #1;
        check("t1 ld stall", a_cpu_stall, 1);
        check("t1 ld rdata early", a_cpu_rdata, 0);
        step();
        check("t1 ld done", a_cpu_done, 1);
        check("t1 ld rdata", a_cpu_rdata, 32'hDEADBEEF);
        check("t1 ld we", a_dmem_we, 0);
        a_cpu_req = 1'b0;

        // simultaneous requests on an idle port: CPU first, DMA right after
        step();
        a_cpu_req = 1'b1;
        a_dma_req = 1'b1; a_dma_we = 1'b1; a_dma_addr = 32'h30; a_dma_wdata = 32'hA5A5A5A5;
        #1;
        check("t3a done early", a_cpu_done, 0);
        check("t3a ack early", a_dma_ack, 0);
        step();
        check("t3a cpu done", a_cpu_done, 1);
        check("t3a no ack", a_dma_ack, 0);
        check("t3a cpu rdata", a_cpu_rdata, 32'hDEADBEEF);
        a_cpu_req = 1'b0;
        step();
        check("t3a ack", a_dma_ack, 1);
        check("t3a no done", a_cpu_done, 0);
        check("t3a dma we", a_dmem_we, 1);
        check("t3a dma addr", a_dmem_addr, 32'h30);
        check("t3a dma wdata", a_dmem_wdata, 32'hA5A5A5A5);
        a_dma_req = 1'b0;
        step();
        check("t3a idle ack", a_dma_ack, 0);
        check("t3a idle addr", a_dmem_addr, 0);

        // both requests held: fairness decides whether DMA ever gets in
        a_cpu_req = 1'b1; a_dma_req = 1'b1; a_dma_we = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            check($sformatf("t4 c%0d ack", i), a_dma_ack, FAIR && i == 5);
            check($sformatf("t4 c%0d done", i), a_cpu_done, !(FAIR && i == 5));
            check($sformatf("t4 c%0d dma rdata", i), a_dma_rdata, (FAIR && i == 5) ? 32'hA5A5A5A5 : 32'h0);
            check($sformatf("t4 c%0d cpu rdata", i), a_cpu_rdata, (FAIR && i == 5) ? 32'h0 : 32'hDEADBEEF);
            if (i == 8) begin
                a_cpu_req = 1'b0; a_dma_req = 1'b0;
            end
        end

        // ACC_CYCLES=3 store
        step();
        b_cpu_req = 1'b1; b_cpu_we = 1'b1; b_cpu_addr = 32'h20; b_cpu_wdata = 32'h12345678;
        #1;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) step();
            check($sformatf("t2 c%0d stall", i), b_cpu_stall, i != 3);
            check($sformatf("t2 c%0d done", i), b_cpu_done, i == 3);
            check($sformatf("t2 c%0d we", i), b_dmem_we, i == 3);
            check($sformatf("t2 c%0d addr", i), b_dmem_addr, (i == 0) ? 32'h0 : 32'h20);
        end
        b_cpu_req = 1'b0;

        // ACC_CYCLES=3 simultaneous load + DMA write, no gap between them
        step();
        b_cpu_req = 1'b1; b_cpu_we = 1'b0;
        b_dma_req = 1'b1; b_dma_we = 1'b1; b_dma_addr = 32'h40; b_dma_wdata = 32'hCAFEF00D;
        for (int i = 1; i <= 6; i++) begin
            step();
            check($sformatf("t3b c%0d done", i), b_cpu_done, i == 3);
            check($sformatf("t3b c%0d ack", i), b_dma_ack, i == 6);
            check($sformatf("t3b c%0d we", i), b_dmem_we, i == 6);
            check($sformatf("t3b c%0d cpu rdata", i), b_cpu_rdata, (i == 3) ? 32'h12345678 : 32'h0);
            if (i == 3) b_cpu_req = 1'b0;
            if (i == 6) b_dma_req = 1'b0;
        end

        // reset in cycle 2 of a 3-cycle DMA write abandons it
        step();
        b_dma_req = 1'b1; b_dma_we = 1'b1; b_dma_addr = 32'h50; b_dma_wdata = 32'h55AA55AA;
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("t5 rst ack", b_dma_ack, 0);
        check("t5 rst we", b_dmem_we, 0);
        check("t5 rst addr", b_dmem_addr, 0);
        step();
        check("t5 rst hold ack", b_dma_ack, 0);
        check("t5 rst hold we", b_dmem_we, 0);
        b_dma_req = 1'b0;
        rst_n = 1'b1;
        step();
        check("t5 idle addr", b_dmem_addr, 0);
        check("t5 idle ack", b_dma_ack, 0);
        check("t5 no write at 0x50", b_bad_wr, 0);

        // new DMA read served normally; request dropped mid-access still completes once
        b_dma_req = 1'b1; b_dma_we = 1'b0; b_dma_addr = 32'h40;
        for (int i = 1; i <= 4; i++) begin
            step();
            check($sformatf("t6 c%0d ack", i), b_dma_ack, i == 3);
            check($sformatf("t6 c%0d rdata", i), b_dma_rdata, (i == 3) ? 32'hCAFEF00D : 32'h0);
            if (i == 2) b_dma_req = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
